// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF reference coprocessor.
// Optional MUL support is enabled by the CVXIF_COPRO_MUL_EN macro.
package cvxif_copro_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    XOR = 3'd1,
    NOP = 3'd2,
    EXC = 3'd3,
    MUL = 3'd4
  } copro_op_e;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } entry_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } res_fsm_e;

  // Width-independent part of a buffer entry; id and operands live in
  // separately parameterised arrays in the responder.
  typedef struct packed {
    entry_state_e state;
    copro_op_e    op;
    logic [4:0]   rd;
    logic         we;
  } copro_entry_t;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational custom-0 decoder: instruction word -> accept/writeback/op/rd.
// funct3=100 (MUL) is only accepted when CVXIF_COPRO_MUL_EN is defined.
module cvxif_copro_decoder
  import cvxif_copro_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        accept_o,
  output logic        writeback_o,
  output copro_op_e   op_o,
  output logic [4:0]  rd_o
);

  logic [2:0] funct3;
  logic       unused_instr;

  assign funct3       = instr_i[14:12];
  assign rd_o         = instr_i[11:7];
  assign unused_instr = ^instr_i[31:15];

  always_comb begin
    accept_o    = 1'b0;
    writeback_o = 1'b0;
    op_o        = NOP;
    if (instr_i[6:0] == OPCODE_CUSTOM0) begin
      case (funct3)
        3'b000: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          op_o        = ADD;
        end
        3'b001: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          op_o        = XOR;
        end
        3'b010: begin
          accept_o = 1'b1;
          op_o     = NOP;
        end
        3'b011: begin
          accept_o = 1'b1;
          op_o     = EXC;
        end
`ifdef CVXIF_COPRO_MUL_EN
        3'b100: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          op_o        = MUL;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: in-order issue buffer, commit/kill tracking
// and a ready/valid result channel. Define CVXIF_COPRO_MUL_EN to add MUL.
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [2*XLEN-1:0]   issue_rs_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                result_exc_o,
  output logic [5:0]          result_exccode_o,
  output logic                protocol_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  typedef logic [AW:0] ptr_t;

  copro_entry_t        ent_q [DEPTH];
  copro_entry_t        ent_d [DEPTH];
  logic [ID_WIDTH-1:0] id_q  [DEPTH];
  logic [ID_WIDTH-1:0] id_d  [DEPTH];
  logic [XLEN-1:0]     opa_q [DEPTH];
  logic [XLEN-1:0]     opa_d [DEPTH];
`ifdef CVXIF_COPRO_MUL_EN
  logic [XLEN-1:0]     opb_q [DEPTH];
  logic [XLEN-1:0]     opb_d [DEPTH];
  logic [1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     mul_res;
`endif

  ptr_t     wr_ptr_q, wr_ptr_d;
  ptr_t     rd_ptr_q, rd_ptr_d;
  ptr_t     cm_ptr_q, cm_ptr_d;
  res_fsm_e state_q, state_d;
  logic     err_q, err_d;

  logic         dec_accept, dec_wb;
  copro_op_e    dec_op;
  logic [4:0]   dec_rd;
  logic [AW-1:0] wr_idx, rd_idx, cm_idx, nx_idx;
  copro_entry_t head;
  logic         empty, head_committed, head_killed, next_committed;
  logic         res_pop, pop, full, issue_fire;
  ptr_t         rd_ptr_pop;
  logic [XLEN-1:0] rs1, rs2, issue_val;

  cvxif_copro_decoder u_decoder (
    .instr_i     (issue_instr_i),
    .accept_o    (dec_accept),
    .writeback_o (dec_wb),
    .op_o        (dec_op),
    .rd_o        (dec_rd)
  );

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign cm_idx = cm_ptr_q[AW-1:0];
  assign nx_idx = rd_idx + AW'(1);
  assign head   = ent_q[rd_idx];
  assign rs1    = issue_rs_i[XLEN-1:0];
  assign rs2    = issue_rs_i[2*XLEN-1:XLEN];

  assign empty          = (wr_ptr_q == rd_ptr_q);
  assign head_committed = !empty && (head.state == COMMITTED);
  assign head_killed    = !empty && (head.state == KILLED);
  assign next_committed = ((rd_ptr_q + ptr_t'(1)) != wr_ptr_q) &&
                          (ent_q[nx_idx].state == COMMITTED);

  assign result_valid_o = (state_q == DONE);
  assign res_pop        = result_valid_o && result_ready_i;
  assign pop            = res_pop || ((state_q == IDLE) && head_killed);
  assign rd_ptr_pop     = rd_ptr_q + ptr_t'(pop);

  // Fullness looks past this cycle's pop so a draining full buffer keeps accepting.
  assign full           = ((wr_ptr_q - rd_ptr_pop) == DEPTH_P);
  assign issue_ready_o  = !full && (&issue_rs_valid_i);
  assign issue_fire     = issue_valid_i && issue_ready_o && dec_accept;

  assign issue_accept_o    = dec_accept;
  assign issue_writeback_o = dec_wb;

  assign result_id_o      = head_committed ? id_q[rd_idx]  : '0;
  assign result_data_o    = head_committed ? opa_q[rd_idx] : '0;
  assign result_rd_o      = head_committed ? head.rd       : '0;
  assign result_we_o      = head_committed && head.we;
  assign result_exc_o     = head_committed && (head.op == EXC);
  assign result_exccode_o = result_exc_o ? 6'd2 : 6'd0;
  assign protocol_err_o   = err_q;

`ifdef CVXIF_COPRO_MUL_EN
  assign mul_res = opa_q[rd_idx] * opb_q[rd_idx];
`endif

  always_comb begin
    case (dec_op)
      ADD:     issue_val = rs1 + rs2;
      XOR:     issue_val = rs1 ^ rs2;
      MUL:     issue_val = rs1;
      default: issue_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
`ifdef CVXIF_COPRO_MUL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (head_committed) begin
          state_d = EXEC;
`ifdef CVXIF_COPRO_MUL_EN
          cnt_d   = 2'd2;
`endif
        end
      end
      EXEC: begin
`ifdef CVXIF_COPRO_MUL_EN
        if ((head.op == MUL) && (cnt_q != 2'd0)) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        if (res_pop) begin
          if (next_committed) begin
            state_d = EXEC;
`ifdef CVXIF_COPRO_MUL_EN
            cnt_d   = 2'd2;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop, commit and issue are applied in that order so a full-and-draining
  // buffer can reuse the freed head slot in the same cycle.
  always_comb begin
    ent_d    = ent_q;
    id_d     = id_q;
    opa_d    = opa_q;
`ifdef CVXIF_COPRO_MUL_EN
    opb_d    = opb_q;
`endif
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_pop;
    cm_ptr_d = cm_ptr_q;
    err_d    = err_q;

    if (pop) begin
      ent_d[rd_idx].state = EMPTY;
    end

`ifdef CVXIF_COPRO_MUL_EN
    if ((state_q == EXEC) && (head.op == MUL) && (cnt_q == 2'd0)) begin
      opa_d[rd_idx] = mul_res;
    end
`endif

    if (commit_valid_i) begin
      if ((cm_ptr_q == wr_ptr_q) || (commit_id_i != id_q[cm_idx])) begin
        err_d = 1'b1;
      end else begin
        ent_d[cm_idx].state = commit_kill_i ? KILLED : COMMITTED;
        cm_ptr_d            = cm_ptr_q + ptr_t'(1);
      end
    end

    if (issue_fire) begin
      ent_d[wr_idx] = '{state: ISSUED, op: dec_op, rd: dec_rd, we: dec_wb};
      id_d[wr_idx]  = issue_id_i;
      opa_d[wr_idx] = issue_val;
`ifdef CVXIF_COPRO_MUL_EN
      opb_d[wr_idx] = rs2;
`endif
      wr_ptr_d      = wr_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{state: EMPTY, op: ADD, rd: 5'd0, we: 1'b0};
        id_q[i]  <= '0;
        opa_q[i] <= '0;
`ifdef CVXIF_COPRO_MUL_EN
        opb_q[i] <= '0;
`endif
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
      state_q  <= IDLE;
      err_q    <= 1'b0;
`ifdef CVXIF_COPRO_MUL_EN
      cnt_q    <= 2'd0;
`endif
    end else begin
      ent_q    <= ent_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
`ifdef CVXIF_COPRO_MUL_EN
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed self-checking bench for cvxif_copro_responder.
// MUL scenarios run when CVXIF_COPRO_MUL_EN is defined.
module tb_cvxif_copro_responder;

  logic        clk_i;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [63:0] issue_rs_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        result_exc_o;
  logic [5:0]  result_exccode_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  cvxif_copro_responder dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs_i        (issue_rs_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o),
    .result_exc_o      (result_exc_o),
    .result_exccode_o  (result_exccode_o),
    .protocol_err_o    (protocol_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                             input logic [31:0] rs1, input logic [31:0] rs2);
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    issue_rs_i    = {rs2, rs1};
  endtask

  task automatic end_issue();
    issue_valid_i = 1'b0;
    issue_instr_i = 32'd0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (result_valid_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    issue_valid_i = 1'b0; issue_instr_i = 32'd0; issue_id_i = 4'd0;
    issue_rs_i = 64'd0; issue_rs_valid_i = 2'b11;
    commit_valid_i = 1'b0; commit_id_i = 4'd0; commit_kill_i = 1'b0;
    result_ready_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (result_valid_o !== 1'b0 || protocol_err_o !== 1'b0 || result_data_o !== 32'd0 ||
        result_id_o !== 4'd0 || issue_accept_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b err=%b data=%h id=%h acc=%b, required all 0",
               result_valid_o, protocol_err_o, result_data_o, result_id_o, issue_accept_o);
    end
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b required 1", issue_ready_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive_issue(mk(3'b000, 5'd9), 4'd3, 32'd5, 32'd7);
    #1;
    checks++;
    if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_accept: acc=%b wb=%b required 1 1", issue_accept_o, issue_writeback_o);
    end
    tick();
    end_issue();
    do_commit(4'd3, 1'b0);
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_early_c0: valid=%b required 0", result_valid_o);
    end
    tick();
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_early_c1: valid=%b required 0", result_valid_o);
    end
    tick();
    checks++;
    if (result_valid_o !== 1'b1 || result_id_o !== 4'd3 || result_data_o !== 32'd12 ||
        result_we_o !== 1'b1 || result_rd_o !== 5'd9 || result_exc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_result: valid=%b id=%0d data=%h we=%b rd=%0d exc=%b required 1 3 0000000c 1 9 0",
               result_valid_o, result_id_o, result_data_o, result_we_o, result_rd_o, result_exc_o);
    end
    result_ready_i = 1'b1;
    tick();
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_pop: valid=%b required 0", result_valid_o);
    end
  endtask

  task automatic test_nonaccept();
    bit saw;
    drive_issue(32'h0000_0013, 4'd2, 32'd1, 32'd1);
    #1;
    checks++;
    if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonaccept_dec: acc=%b wb=%b rdy=%b required 0 0 1",
               issue_accept_o, issue_writeback_o, issue_ready_o);
    end
    tick();
    end_issue();
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (result_valid_o) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nonaccept_noresult: saw valid=%b required 0", saw);
    end
  endtask

  task automatic test_full_backpressure();
    bit seen;
    logic [31:0] exp;
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_issue(mk(3'b001, 5'(10 + k)), 4'(4 + k), 32'hA5A5_0000 + 32'(k), 32'h0F0F_0F0F);
      #1;
      checks++;
      if (issue_ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_ready_%0d: got %b required 1", k, issue_ready_o);
      end
      tick();
    end
    drive_issue(mk(3'b001, 5'd20), 4'd8, 32'd0, 32'd0);
    #1;
    checks++;
    if (issue_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: got %b required 0", issue_ready_o);
    end
    end_issue();
    for (int k = 0; k < 4; k++) do_commit(4'(4 + k), 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL full_first_valid: timeout valid=%b required 1", result_valid_o);
    end
    exp = 32'hA5A5_0000 ^ 32'h0F0F_0F0F;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (result_valid_o !== 1'b1 || result_id_o !== 4'd4 || result_data_o !== exp ||
          result_rd_o !== 5'd10 || issue_ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_stable_%0d: valid=%b id=%0d data=%h rd=%0d rdy=%b required 1 4 %h 10 0",
                 c, result_valid_o, result_id_o, result_data_o, result_rd_o, issue_ready_o, exp);
      end
      tick();
    end
    result_ready_i = 1'b1;
    #1;
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_popping_ready: got %b required 1", issue_ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, seen);
      exp = (32'hA5A5_0000 + 32'(k)) ^ 32'h0F0F_0F0F;
      checks++;
      if (!seen || result_id_o !== 4'(4 + k) || result_data_o !== exp) begin
        errors++;
        $display("[TB] FAIL order_%0d: seen=%b id=%0d data=%h required 1 %0d %h",
                 k, seen, result_id_o, result_data_o, 4 + k, exp);
      end
      tick();
    end
  endtask

  task automatic test_kill();
    bit seen;
    bit extra;
    result_ready_i = 1'b1;
    drive_issue(mk(3'b000, 5'd1), 4'd1, 32'd1, 32'd1);
    tick();
    drive_issue(mk(3'b000, 5'd2), 4'd2, 32'd3, 32'd4);
    tick();
    end_issue();
    do_commit(4'd1, 1'b1);
    do_commit(4'd2, 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen || result_id_o !== 4'd2 || result_data_o !== 32'd7 || result_rd_o !== 5'd2) begin
      errors++;
      $display("[TB] FAIL kill_result: seen=%b id=%0d data=%h rd=%0d required 1 2 00000007 2",
               seen, result_id_o, result_data_o, result_rd_o);
    end
    tick();
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (result_valid_o) extra = 1'b1;
      tick();
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_single: extra result=%b required 0", extra);
    end
  endtask

  task automatic test_exc_err();
    bit seen;
    drive_issue(mk(3'b011, 5'd4), 4'd0, 32'd0, 32'd0);
    #1;
    checks++;
    if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exc_accept: acc=%b wb=%b required 1 0", issue_accept_o, issue_writeback_o);
    end
    tick();
    end_issue();
    do_commit(4'd0, 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen || result_id_o !== 4'd0 || result_exc_o !== 1'b1 || result_exccode_o !== 6'd2 ||
        result_we_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exc_result: seen=%b id=%0d exc=%b code=%0d we=%b required 1 0 1 2 0",
               seen, result_id_o, result_exc_o, result_exccode_o, result_we_o);
    end
    tick();
    checks++;
    if (protocol_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clean: got %b required 0", protocol_err_o);
    end
    do_commit(4'd5, 1'b0);
    checks++;
    if (protocol_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_empty_commit: got %b required 1", protocol_err_o);
    end
    repeat (3) tick();
    checks++;
    if (protocol_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b required 1", protocol_err_o);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    result_ready_i = 1'b0;
    drive_issue(mk(3'b000, 5'd3), 4'd1, 32'd10, 32'd20);
    tick();
    drive_issue(mk(3'b000, 5'd3), 4'd2, 32'd11, 32'd21);
    tick();
    end_issue();
    do_commit(4'd1, 1'b0);
    tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (result_valid_o !== 1'b0 || protocol_err_o !== 1'b0 || issue_ready_o !== 1'b1 ||
        result_id_o !== 4'd0 || result_data_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: valid=%b err=%b rdy=%b id=%0d data=%h required 0 0 1 0 0",
               result_valid_o, protocol_err_o, issue_ready_o, result_id_o, result_data_o);
    end
    tick();
    rst_ni = 1'b1;
    result_ready_i = 1'b1;
    tick();
    drive_issue(mk(3'b000, 5'd7), 4'd6, 32'd3, 32'd4);
    tick();
    end_issue();
    do_commit(4'd6, 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen || result_id_o !== 4'd6 || result_data_o !== 32'd7 || protocol_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clean: seen=%b id=%0d data=%h err=%b required 1 6 00000007 0",
               seen, result_id_o, result_data_o, protocol_err_o);
    end
    tick();
  endtask

  task automatic test_same_cycle_commit();
    bit seen;
    drive_issue(mk(3'b000, 5'd1), 4'd3, 32'd1, 32'd2);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd3;
    tick();
    commit_valid_i = 1'b0;
    end_issue();
    checks++;
    if (protocol_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_cycle_err: got %b required 1", protocol_err_o);
    end
    do_commit(4'd3, 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen || result_id_o !== 4'd3 || result_data_o !== 32'd3) begin
      errors++;
      $display("[TB] FAIL same_cycle_recommit: seen=%b id=%0d data=%h required 1 3 00000003",
               seen, result_id_o, result_data_o);
    end
    tick();
  endtask

  task automatic test_mul();
`ifdef CVXIF_COPRO_MUL_EN
    bit seen;
    int lat;
    result_ready_i = 1'b1;
    drive_issue(mk(3'b100, 5'd12), 4'd7, 32'hFFFF_FFFF, 32'd2);
    #1;
    checks++;
    if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mul_accept: acc=%b wb=%b required 1 1", issue_accept_o, issue_writeback_o);
    end
    tick();
    end_issue();
    do_commit(4'd7, 1'b0);
    lat = 0;
    while (!result_valid_o && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || result_data_o !== 32'hFFFF_FFFE || result_id_o !== 4'd7) begin
      errors++;
      $display("[TB] FAIL mul_result: lat=%0d data=%h id=%0d required 4 fffffffe 7",
               lat, result_data_o, result_id_o);
    end
    tick();
    drive_issue(mk(3'b100, 5'd12), 4'd8, 32'd9, 32'd9);
    tick();
    end_issue();
    do_commit(4'd8, 1'b0);
    repeat (2) tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (result_valid_o !== 1'b0 || protocol_err_o !== 1'b0 || issue_ready_o !== 1'b1 ||
        result_data_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mul_reset: valid=%b err=%b rdy=%b data=%h required 0 0 1 0",
               result_valid_o, protocol_err_o, issue_ready_o, result_data_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    drive_issue(mk(3'b000, 5'd2), 4'd2, 32'd1, 32'd1);
    tick();
    end_issue();
    do_commit(4'd2, 1'b0);
    wait_valid(10, seen);
    checks++;
    if (!seen || result_id_o !== 4'd2 || result_data_o !== 32'd2) begin
      errors++;
      $display("[TB] FAIL mul_reset_clean: seen=%b id=%0d data=%h required 1 2 00000002",
               seen, result_id_o, result_data_o);
    end
    tick();
`else
    drive_issue(mk(3'b100, 5'd12), 4'd7, 32'hFFFF_FFFF, 32'd2);
    #1;
    checks++;
    if (issue_accept_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_disabled: acc=%b required 0", issue_accept_o);
    end
    tick();
    end_issue();
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_nonaccept();
    test_full_backpressure();
    test_kill();
    test_exc_err();
    test_reset_mid();
    test_same_cycle_commit();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
